// File: rtl/mux_scan_ctrl_pkg.sv
// mux_scan_ctrl_pkg
// Shared definitions for the mux/demux channel scanners:
//   - scan_state_t : two-state scanner encoding (IDLE / SCAN)
//   - DEF_SEL_W    : default select width (8 channels)
//   - DEF_DWELL    : default dwell cycles per channel
//   - DWELL_CNT_W  : dwell counter width, wide enough for the 1..255 dwell range
package mux_scan_ctrl_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } scan_state_t;

    localparam int DEF_SEL_W   = 3;
    localparam int DEF_DWELL   = 4;
    localparam int DWELL_CNT_W = 8;

endpackage

// File: rtl/mux_scan_ctrl_dwell_counter.sv
// mux_dwell_counter
// Counts the cycles a channel is held on the select lines and flags the final
// dwell cycle, at which the scanner samples and advances.
// Ports:
//   clk   in  system clock
//   rst_n in  synchronous active-low reset
//   clr   in  synchronous clear (scanner idle or aborting)
//   en    in  count enable (scanner active)
//   last  out high while the count sits on its final dwell cycle
module mux_dwell_counter
    import mux_scan_ctrl_pkg::*;
#(
    parameter int DWELL = DEF_DWELL
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic last
);

    localparam logic [DWELL_CNT_W-1:0] LAST_CNT = DWELL_CNT_W'(DWELL - 1);

    logic [DWELL_CNT_W-1:0] dcnt;

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            dcnt <= '0;
        end else if (en) begin
            if (last) begin
                dcnt <= '0;
            end else begin
                dcnt <= dcnt + DWELL_CNT_W'(1);
            end
        end
    end

    // With DWELL=1 the count never leaves zero, so every cycle is final.
    assign last = (dcnt == LAST_CNT);

endmodule

// File: rtl/mux_scan_ctrl.sv
// mux_scan_ctrl
// Steps the select of an external N_CH:1 mux through every channel, dwells
// DWELL cycles per channel, samples the mux output on the last dwell edge and
// packs the samples into a frame offered on a valid/ready handshake.
// Ports:
//   clk         in  system clock
//   rst_n       in  synchronous active-low reset
//   start       in  begin a scan (IDLE only)
//   mode        in  0 = single scan, 1 = continuous
//   abort       in  stop the scan, discarding the partial frame
//   sel         out registered mux select
//   mux_out     in  mux output for the current sel
//   frame       out assembled samples, bit k = channel k
//   frame_valid out frame holds unconsumed data
//   frame_ready in  consumer accepts the frame
//   busy        out scanner is in SCAN
//   overflow    out sticky: an unconsumed frame was overwritten
module mux_scan_ctrl
    import mux_scan_ctrl_pkg::*;
#(
    parameter int SEL_W = DEF_SEL_W,
    parameter int DWELL = DEF_DWELL
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  mode,
    input  logic                  abort,
    output logic [SEL_W-1:0]      sel,
    input  logic                  mux_out,
    output logic [(1<<SEL_W)-1:0] frame,
    output logic                  frame_valid,
    input  logic                  frame_ready,
    output logic                  busy,
    output logic                  overflow
);

    localparam int N_CH = 1 << SEL_W;

    scan_state_t      state;
    scan_state_t      state_nxt;
    logic [SEL_W-1:0] ch;
    logic [N_CH-1:0]  shadow;
    logic [N_CH-1:0]  frame_nxt;
    logic             scanning;
    logic             dwell_last;
    logic             sample;
    logic             last_ch;
    logic             load;

    assign scanning = (state == SCAN);
    // abort outranks a coincident sample: the partial frame is dropped.
    assign sample   = scanning && !abort && dwell_last;
    assign last_ch  = (ch == {SEL_W{1'b1}});
    assign load     = sample && last_ch;

    // ch is held at zero whenever the scanner is idle, so it doubles as the
    // registered select.
    assign sel = ch;

    mux_dwell_counter #(
        .DWELL (DWELL)
    ) u_dwell (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (!scanning || abort),
        .en    (scanning),
        .last  (dwell_last)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; mode is only consulted on the final-channel sample.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start && !abort) begin
                    state_nxt = SCAN;
                end
            end
            SCAN: begin
                if (abort) begin
                    state_nxt = IDLE;
                end else if (load && !mode) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs decoded from state
    always_comb begin
        busy = (state == SCAN);
    end

    // Channel counter and per-channel shadow samples
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ch     <= '0;
            shadow <= '0;
        end else if (scanning && abort) begin
            ch     <= '0;
            shadow <= '0;
        end else if (sample) begin
            shadow[ch] <= mux_out;
            ch         <= ch + SEL_W'(1);
        end
    end

    // The last channel goes straight into the frame, bypassing the shadow.
    always_comb begin
        frame_nxt           = shadow;
        frame_nxt[N_CH-1]   = mux_out;
    end

    // Frame hand-off; a load on the same edge as a consume keeps valid high.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            frame       <= '0;
            frame_valid <= 1'b0;
            overflow    <= 1'b0;
        end else if (load) begin
            frame       <= frame_nxt;
            frame_valid <= 1'b1;
            if (frame_valid && !frame_ready) begin
                overflow <= 1'b1;
            end
        end else if (frame_valid && frame_ready) begin
            frame_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mux_scan_ctrl.sv
module tb_mux_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    // DUT a: defaults (8 channels, DWELL=4)
    logic       start, mode, abort, frame_ready;
    logic [2:0] sel;
    logic [7:0] mux_in;
    logic       mux_out;
    logic [7:0] frame;
    logic       frame_valid, busy, overflow;
    // DUT b: DWELL=1
    logic       start_b, mode_b, abort_b, frame_ready_b;
    logic [2:0] sel_b;
    logic [7:0] mux_in_b;
    logic       mux_out_b;
    logic [7:0] frame_b;
    logic       frame_valid_b, busy_b, overflow_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // 8:1 data multiplexers
    assign mux_out   = mux_in[sel];
    assign mux_out_b = mux_in_b[sel_b];

    mux_scan_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .mode        (mode),
        .abort       (abort),
        .sel         (sel),
        .mux_out     (mux_out),
        .frame       (frame),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready),
        .busy        (busy),
        .overflow    (overflow)
    );

    mux_scan_ctrl #(.SEL_W(3), .DWELL(1)) dut_b (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start_b),
        .mode        (mode_b),
        .abort       (abort_b),
        .sel         (sel_b),
        .mux_out     (mux_out_b),
        .frame       (frame_b),
        .frame_valid (frame_valid_b),
        .frame_ready (frame_ready_b),
        .busy        (busy_b),
        .overflow    (overflow_b)
    );

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; mode = 1'b0; abort = 1'b0; frame_ready = 1'b0;
        mux_in = 8'hA6;
        start_b = 1'b0; mode_b = 1'b0; abort_b = 1'b0; frame_ready_b = 1'b0;
        mux_in_b = 8'h96;
        tick(2);
        chk("rst_sel", 32'(sel), 0);
        chk("rst_frame", 32'(frame), 0);
        chk("rst_valid", 32'(frame_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_ovf", 32'(overflow), 0);
        rst_n = 1'b1;
        tick(1);

        // Single scan of 8'hA6
        start = 1'b1;
        tick(1);
        start = 1'b0;
        chk("single_busy", 32'(busy), 1);
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("single_sel%0d", k), 32'(sel), 32'(k));
            tick(2);
            chk($sformatf("single_valid_mid%0d", k), 32'(frame_valid), 0);
            tick(2);
        end
        chk("single_frame", 32'(frame), 32'hA6);
        chk("single_valid", 32'(frame_valid), 1);
        chk("single_idle", 32'(busy), 0);
        chk("single_sel_idle", 32'(sel), 0);
        tick(1);
        chk("single_hold_valid", 32'(frame_valid), 1);
        chk("single_hold_frame", 32'(frame), 32'hA6);

        // Consume, then continuous with ready=1
        frame_ready = 1'b1;
        tick(1);
        chk("consume_valid", 32'(frame_valid), 0);
        mode = 1'b1;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(32);
        chk("cont1_frame", 32'(frame), 32'hA6);
        chk("cont1_valid", 32'(frame_valid), 1);
        chk("cont1_busy", 32'(busy), 1);
        mux_in = 8'h3C;
        tick(1);
        chk("cont1_clear", 32'(frame_valid), 0);
        tick(30);
        chk("cont2_early", 32'(frame_valid), 0);
        tick(1);
        chk("cont2_frame", 32'(frame), 32'h3C);
        chk("cont2_valid", 32'(frame_valid), 1);
        chk("cont2_ovf", 32'(overflow), 0);
        tick(1);
        chk("cont2_clear", 32'(frame_valid), 0);

        // Abort at channel 3 of the third continuous frame
        tick(11);
        chk("abort_sel3", 32'(sel), 3);
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        chk("abort_busy", 32'(busy), 0);
        chk("abort_sel", 32'(sel), 0);
        chk("abort_frame", 32'(frame), 32'h3C);
        chk("abort_valid", 32'(frame_valid), 0);
        tick(3);
        chk("abort_stay_idle", 32'(busy), 0);
        mux_in = 8'h5A;
        mode = 1'b0;
        frame_ready = 1'b0;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(32);
        chk("post_abort_frame", 32'(frame), 32'h5A);
        chk("post_abort_valid", 32'(frame_valid), 1);
        chk("post_abort_busy", 32'(busy), 0);

        // Overflow: clear valid, then two continuous frames with ready=0
        frame_ready = 1'b1;
        tick(1);
        frame_ready = 1'b0;
        mux_in = 8'hC3;
        mode = 1'b1;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(32);
        chk("ovf1_frame", 32'(frame), 32'hC3);
        chk("ovf1_ovf", 32'(overflow), 0);
        mux_in = 8'h81;
        tick(32);
        chk("ovf2_frame", 32'(frame), 32'h81);
        chk("ovf2_valid", 32'(frame_valid), 1);
        chk("ovf2_ovf", 32'(overflow), 1);
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        tick(3);
        chk("ovf_sticky", 32'(overflow), 1);
        chk("ovf_idle", 32'(busy), 0);

        // Reset mid-scan at channel 5
        mode = 1'b0;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(20);
        chk("mid_sel5", 32'(sel), 5);
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        chk("mrst_sel", 32'(sel), 0);
        chk("mrst_frame", 32'(frame), 0);
        chk("mrst_valid", 32'(frame_valid), 0);
        chk("mrst_busy", 32'(busy), 0);
        chk("mrst_ovf", 32'(overflow), 0);

        // Handshake collision: consume on the same edge as a new load
        mux_in = 8'hE7;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(32);
        chk("coll1_frame", 32'(frame), 32'hE7);
        mux_in = 8'h18;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(31);
        chk("coll_hold_frame", 32'(frame), 32'hE7);
        frame_ready = 1'b1;
        tick(1);
        chk("coll_valid", 32'(frame_valid), 1);
        chk("coll_frame", 32'(frame), 32'h18);
        chk("coll_ovf", 32'(overflow), 0);
        tick(1);
        chk("coll_consumed", 32'(frame_valid), 0);
        frame_ready = 1'b0;

        // DWELL=1: start+abort together, then start alone
        start_b = 1'b1;
        abort_b = 1'b1;
        tick(1);
        start_b = 1'b0;
        abort_b = 1'b0;
        chk("d1_both_busy", 32'(busy_b), 0);
        chk("d1_both_sel", 32'(sel_b), 0);
        tick(2);
        chk("d1_still_idle", 32'(busy_b), 0);
        start_b = 1'b1;
        tick(1);
        start_b = 1'b0;
        chk("d1_busy", 32'(busy_b), 1);
        tick(3);
        chk("d1_sel3", 32'(sel_b), 3);
        tick(4);
        chk("d1_valid_early", 32'(frame_valid_b), 0);
        tick(1);
        chk("d1_valid", 32'(frame_valid_b), 1);
        chk("d1_frame", 32'(frame_b), 32'h96);
        chk("d1_idle", 32'(busy_b), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mux_scan_ctrl.md
# mux_scan_ctrl

Sequential scanner that sits directly upstream and downstream of the 8:1 data multiplexer. It drives the mux select lines through every channel, dwells a programmable number of cycles per channel, and samples the mux output. It then assembles the samples into a parallel frame, which it presents to the consumer on a valid/ready handshake. It supports single-shot and continuous scanning, abort, and sticky overflow detection.

## Interface
Parameters:
- SEL_W, 3, select width; channel count N_CH = 2**SEL_W (8 by default)
- DWELL, 4, cycles each channel is held on sel; legal range 1..255

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst_n  in  1  reset, synchronous, active-low
- start  in  1  begin a scan; honoured only in IDLE
- mode  in  1  0 = single scan, 1 = continuous scan
- abort  in  1  terminate scan; priority over start
- sel  out  SEL_W  registered mux select (S2..S0 order, MSB first)
- mux_out  in  1  combinational mux output for current sel
- frame  out  N_CH  assembled samples; bit k = sample of channel k
- frame_valid  out  1  frame holds unconsumed data
- frame_ready  in  1  consumer accepts frame when high with frame_valid
- busy  out  1  high in SCAN
- overflow  out  1  sticky; an unconsumed frame was overwritten

## Operation
- Reset (rst_n low at edge) produces the following values:
  - state = IDLE, sel = 0, frame = 0, frame_valid = 0, busy = 0, overflow = 0.
  - The dwell counter, channel counter and shadow register are cleared.
  - Reset applies mid-scan with no partial frame retained.
- The state machine has two states:
  - IDLE: sel = 0. If start=1 and abort=0, go to SCAN with ch=0 and dcnt=0.
  - SCAN: sel = ch. Each cycle dcnt increments.
  - When dcnt == DWELL-1, the block does the following at that edge:
    - shadow[ch] <= mux_out, dcnt <= 0, ch <= ch+1 (wraps N_CH-1 -> 0).
  - Last-channel sample (ch == N_CH-1 at sample edge):
    - frame <= shadow with bit N_CH-1 = mux_out; frame_valid <= 1.
    - If mode=1, stay in SCAN at ch=0; else go to IDLE.
    - mode is sampled only at this edge.
- abort=1 in SCAN forces IDLE at the next edge:
  - shadow, ch and dcnt are cleared; frame and frame_valid are untouched.
  - abort in IDLE has no effect. start is ignored while in SCAN.
- Handshake rules:
  - frame_valid && frame_ready at an edge clears frame_valid.
  - A new frame load on that same edge wins: frame_valid stays 1 and overflow is not set.
  - frame is stable while frame_valid=1, except on overflow.
- Overflow rules:
  - A frame load while frame_valid=1 and frame_ready=0 replaces frame and sets overflow.
  - overflow clears only on reset.
- DWELL=1 samples every cycle. Channel advance uses no arithmetic beyond SEL_W-bit modulo wrap.

## Timing
- sel is registered. The mux output for sel is sampled at the last edge of the dwell, giving DWELL-1 cycles of settling margin.
- Latency: with start sampled at edge E0, SCAN begins after E0.
  - Channel k is driven during cycles E0+1+k·DWELL .. E0+(k+1)·DWELL.
  - frame_valid rises at edge E0 + N_CH·DWELL; for the defaults this is E0+32.
- Continuous mode: frames complete every N_CH·DWELL cycles with no gap cycle.
- busy equals (state==SCAN) and updates on the same edge as the state.

## Structure
- A shared package/header holds the state encodings (IDLE=1'b0, SCAN=1'b1) and the default SEL_W/DWELL constants reused by mux and demux blocks.
- One natural sub-module is mux_dwell_counter: it counts dwell cycles and flags the final one, and is reusable by the demux scanner.
- Everything else is flat. The mux itself is instantiated only in the testbench.

## Test plan
- Single scan: mux inputs = 8'b1010_0110, DWELL=4, pulse start, hold frame_ready=0.
  - Required: sel steps 0..7 holding 4 cycles each.
  - Required: frame=8'hA6 and frame_valid=1 at start edge+32.
  - Required: return to IDLE with busy=0.
- Continuous with ready=1: mode=1, inputs change to 8'h3C after the first frame.
  - Required: the second frame = 8'h3C exactly 32 cycles after the first.
  - Required: frame_valid clears one cycle after each load, and overflow stays 0.
- Overflow: mode=1, frame_ready=0 throughout.
  - Required: at the second frame load, frame updates and overflow=1, remaining set until reset.
- Abort mid-scan: abort at channel 3.
  - Required: IDLE next cycle with sel=0.
  - Required: the prior frame/frame_valid are unchanged.
  - Required: a subsequent start yields a full correct frame.
- Reset mid-scan and handshake collision:
  - rst_n=0 for one edge at channel 5 gives all outputs at their reset values.
  - With frame_ready=1 on the load edge, frame_valid remains 1 with no overflow.
- DWELL=1 with start and abort asserted together:
  - start+abort together leaves the block in IDLE.
  - A start alone gives frame_valid at start edge+8.
